// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_pkg
// Description : Opcode encoding shared by the SPI RAM slave controller.
// Revision    : 1.0 - initial parametrised dual-pointer release
// ============================================================================
package spi_ram_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_WR_ADDR = 2'b00;
  localparam opcode_t OP_WR_DATA = 2'b01;
  localparam opcode_t OP_RD_ADDR = 2'b10;
  localparam opcode_t OP_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_mem
// Description : DATA_W x MEM_DEPTH storage array (never reset) with a
//               synchronous write port and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read register; holds its value until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_ctrl
// Description : Command-driven RAM slave. Decodes 2-bit opcodes from SPI
//               frames, keeps independent write/read pointers with optional
//               auto-increment, returns read data with a tx_valid pulse and
//               flags rejected commands with an err pulse.
// Revision    : 1.0 - supersedes fixed 8-bit/256-entry single-pointer RAM
// ============================================================================
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  // Elaboration-time parameter sanity.
  if (ADDR_W > DATA_W) begin : g_chk_addr_w
    $error("spi_ram_ctrl: ADDR_W must not exceed DATA_W");
  end
  if (MEM_DEPTH < 2 || MEM_DEPTH > (1 << DATA_W)) begin : g_chk_depth
    $error("spi_ram_ctrl: MEM_DEPTH must lie in 2 .. 2**DATA_W");
  end

  // One extra bit so MEM_DEPTH == 2**DATA_W is representable.
  localparam logic [DATA_W:0]   C_DEPTH = (DATA_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(MEM_DEPTH - 1);

  opcode_t           w_op;
  logic [DATA_W-1:0] w_payload;
  logic              w_in_range;

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic              r_wr_armed, r_rd_armed, w_wr_armed_nxt, w_rd_armed_nxt;
  logic              r_err, r_tx_valid, w_err_nxt, w_tx_valid_nxt;
  logic              w_mem_we, w_mem_re;

  assign w_op       = din[DATA_W+1:DATA_W];
  assign w_payload  = din[DATA_W-1:0];
  // Whole payload is compared, so stray bits above ADDR_W are rejected too.
  assign w_in_range = ({1'b0, w_payload} < C_DEPTH);

  // Post-increment with wrap at MEM_DEPTH-1 (depth need not be a power of two).
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  // Command decode: next pointer/flag state, memory strobes and pulses.
  always_comb begin
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_armed_nxt = r_wr_armed;
    w_rd_armed_nxt = r_rd_armed;
    w_err_nxt      = 1'b0;
    w_tx_valid_nxt = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_re       = 1'b0;
    if (rx_valid) begin
      case (w_op)
        OP_WR_ADDR: begin
          if (w_in_range) begin
            w_wr_ptr_nxt   = w_payload[ADDR_W-1:0];
            w_wr_armed_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (r_wr_armed) begin
            w_mem_we = 1'b1;
            if (AUTO_INC != 0) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (w_in_range) begin
            w_rd_ptr_nxt   = w_payload[ADDR_W-1:0];
            w_rd_armed_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (r_rd_armed) begin
            w_mem_re       = 1'b1;
            w_tx_valid_nxt = 1'b1;
            if (AUTO_INC != 0) w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: ;  // unknown opcode: no command
      endcase
    end
  end

  // Control state: pointers, armed flags and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_armed <= 1'b0;
      r_rd_armed <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_armed <= w_wr_armed_nxt;
      r_rd_armed <= w_rd_armed_nxt;
      r_err      <= w_err_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  spi_ram_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_mem_we),
    .waddr (r_wr_ptr),
    .wdata (w_payload),
    .re    (w_mem_re),
    .raddr (r_rd_ptr),
    .rdata (dout)
  );

  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_ctrl
// Description : Directed self-checking bench. Three controller instances:
//               defaults, AUTO_INC=1/MEM_DEPTH=5, and MEM_DEPTH=200.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n    [3];
  logic [9:0] din      [3];
  logic       rx_valid [3];
  logic [7:0] dout     [3];
  logic       tx_valid [3];
  logic       err      [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .din(din[0]), .rx_valid(rx_valid[0]),
    .dout(dout[0]), .tx_valid(tx_valid[0]), .err(err[0])
  );

  spi_ram_ctrl #(.DATA_W(8), .MEM_DEPTH(5), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .din(din[1]), .rx_valid(rx_valid[1]),
    .dout(dout[1]), .tx_valid(tx_valid[1]), .err(err[1])
  );

  spi_ram_ctrl #(.DATA_W(8), .MEM_DEPTH(200)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .din(din[2]), .rx_valid(rx_valid[2]),
    .dout(dout[2]), .tx_valid(tx_valid[2]), .err(err[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame on instance d, sampled at the next posedge; returns 1 ns after it.
  task automatic cmd(input int d, input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    din[d]      = {op, pl};
    rx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    rx_valid[d] = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]    = 1'b0;
      din[i]      = '0;
      rx_valid[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_dout",  32'(dout[0]),     32'h0);
    check_val("rst_tx",    32'(tx_valid[0]), 32'h0);
    check_val("rst_err",   32'(err[0]),      32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // ---- instance 0: defaults -------------------------------------------
    cmd(0, RD, 8'h00);
    check_val("disarm_rd_err",  32'(err[0]),      32'h1);
    check_val("disarm_rd_tx",   32'(tx_valid[0]), 32'h0);
    check_val("disarm_rd_dout", 32'(dout[0]),     32'h0);
    idle();
    check_val("err_one_cycle",  32'(err[0]),      32'h0);

    cmd(0, WA, 8'h00);
    check_val("wa0_err", 32'(err[0]), 32'h0);
    cmd(0, WD, 8'h3C);
    check_val("wd3c_err", 32'(err[0]), 32'h0);
    @(negedge clk); rst_n[0] = 1'b0;
    @(negedge clk); rst_n[0] = 1'b1;
    cmd(0, WD, 8'hFF);
    check_val("disarm_wd_err", 32'(err[0]), 32'h1);
    cmd(0, RA, 8'h00);
    check_val("ra0_err", 32'(err[0]), 32'h0);
    cmd(0, RD, 8'h00);
    check_val("mem_kept_tx",   32'(tx_valid[0]), 32'h1);
    check_val("mem_kept_dout", 32'(dout[0]),     32'h3C);

    cmd(0, WA, 8'h10);
    cmd(0, WD, 8'hA5);
    check_val("single_wd_err", 32'(err[0]), 32'h0);
    cmd(0, RA, 8'h10);
    cmd(0, RD, 8'h00);
    check_val("single_dout", 32'(dout[0]),     32'hA5);
    check_val("single_tx",   32'(tx_valid[0]), 32'h1);
    check_val("single_err",  32'(err[0]),      32'h0);
    idle();
    check_val("single_tx_drop",  32'(tx_valid[0]), 32'h0);
    check_val("single_dout_hold", 32'(dout[0]),    32'hA5);
    cmd(0, RD, 8'h00);
    check_val("noinc_rd_dout", 32'(dout[0]), 32'hA5);
    cmd(0, WD, 8'h77);
    cmd(0, RD, 8'h00);
    check_val("noinc_wr_dout", 32'(dout[0]), 32'h77);
    cmd(0, WA, 8'hFF);
    check_val("wa_ff_legal", 32'(err[0]), 32'h0);
    cmd(0, WD, 8'h5E);
    cmd(0, RA, 8'hFF);
    cmd(0, RD, 8'h00);
    check_val("top_addr_dout", 32'(dout[0]), 32'h5E);

    // ---- instance 1: AUTO_INC=1, MEM_DEPTH=5 ----------------------------
    cmd(1, RA, 8'h05);
    check_val("d5_ra5_err", 32'(err[1]), 32'h1);
    cmd(1, RA, 8'h0C);
    check_val("d5_ra_hibits_err", 32'(err[1]), 32'h1);
    cmd(1, RD, 8'h00);
    check_val("d5_still_disarmed_err", 32'(err[1]),      32'h1);
    check_val("d5_still_disarmed_tx",  32'(tx_valid[1]), 32'h0);

    cmd(1, WA, 8'h04);
    cmd(1, WD, 8'h11);
    cmd(1, WD, 8'h22);
    cmd(1, WD, 8'h33);
    cmd(1, WD, 8'h44);
    check_val("burst_wd_err", 32'(err[1]), 32'h0);
    cmd(1, RA, 8'h04);
    cmd(1, RD, 8'h00);
    check_val("burst0_tx",   32'(tx_valid[1]), 32'h1);
    check_val("burst0_dout", 32'(dout[1]),     32'h11);
    cmd(1, RD, 8'h00);
    check_val("burst1_tx",   32'(tx_valid[1]), 32'h1);
    check_val("burst1_dout", 32'(dout[1]),     32'h22);
    cmd(1, RD, 8'h00);
    check_val("burst2_tx",   32'(tx_valid[1]), 32'h1);
    check_val("burst2_dout", 32'(dout[1]),     32'h33);

    @(negedge clk);
    din[1] = {RD, 8'h00};
    rx_valid[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_val("gate_tx",  32'(tx_valid[1]), 32'h0);
      check_val("gate_err", 32'(err[1]),      32'h0);
    end
    cmd(1, RD, 8'h00);
    check_val("gate_ptr_dout", 32'(dout[1]), 32'h44);

    cmd(1, RA, 8'h04);
    cmd(1, RD, 8'h00);
    cmd(1, RD, 8'h00);
    check_val("pre_rst_dout", 32'(dout[1]), 32'h22);
    #3;
    rst_n[1] = 1'b0;
    #1;
    check_val("async_rst_tx",   32'(tx_valid[1]), 32'h0);
    check_val("async_rst_dout", 32'(dout[1]),     32'h0);
    check_val("async_rst_err",  32'(err[1]),      32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    cmd(1, RD, 8'h00);
    check_val("post_rst_rd_err", 32'(err[1]),      32'h1);
    check_val("post_rst_rd_tx",  32'(tx_valid[1]), 32'h0);
    cmd(1, RA, 8'h00);
    cmd(1, RD, 8'h00);
    check_val("post_rst_dout0", 32'(dout[1]), 32'h22);
    cmd(1, RD, 8'h00);
    check_val("post_rst_dout1", 32'(dout[1]), 32'h33);

    // ---- instance 2: MEM_DEPTH=200 --------------------------------------
    cmd(2, WA, 8'hC8);
    check_val("d200_wa_c8_err", 32'(err[2]), 32'h1);
    cmd(2, WD, 8'h12);
    check_val("d200_wd_unarmed_err", 32'(err[2]), 32'h1);
    cmd(2, WA, 8'hC7);
    check_val("d200_wa_c7_err", 32'(err[2]), 32'h0);
    cmd(2, WD, 8'h99);
    check_val("d200_wd_err", 32'(err[2]), 32'h0);
    cmd(2, RA, 8'hC9);
    check_val("d200_ra_c9_err", 32'(err[2]), 32'h1);
    cmd(2, RA, 8'hC7);
    cmd(2, RD, 8'h00);
    check_val("d200_dout", 32'(dout[2]),     32'h99);
    check_val("d200_tx",   32'(tx_valid[2]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised command-driven RAM slave between the SPI slave deserialiser and the serialiser. It decodes 2-bit opcodes from each received frame and keeps independent write and read address pointers, with optional auto-increment burst mode. Reads return one data word with a single-cycle `tx_valid` pulse. Illegal sequences raise a one-cycle `err` pulse. It supersedes the fixed 8-bit/256-entry single-pointer RAM.

## Interface
Parameters:
- `DATA_W`, 8: memory word width and frame payload width.
- `MEM_DEPTH`, 256: number of words. Any value from 2 to 2**DATA_W; need not be a power of two.
- `ADDR_W`, $clog2(MEM_DEPTH): pointer width. Must be ≤ DATA_W; elaboration fails otherwise.
- `AUTO_INC`, 0: when 1, pointers post-increment after each data access.

Ports:
- `clk`, in, 1: the single clock. All logic is on posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, DATA_W+2: frame. `din[DATA_W+1:DATA_W]` is the opcode; `din[DATA_W-1:0]` is the payload.
- `rx_valid`, in, 1: frame valid. Qualifies every opcode, including read-data.
- `dout`, out, DATA_W: read data.
- `tx_valid`, out, 1: one-cycle pulse; `dout` is valid while it is high.
- `err`, out, 1: one-cycle pulse flagging a rejected command.

## Operation
- Opcodes, acted on only when `rx_valid`=1; exactly one command per cycle:
  - 00 WR_ADDR: `wr_ptr` ← payload[ADDR_W-1:0]; set `wr_armed`.
  - 01 WR_DATA: `mem[wr_ptr]` ← payload.
  - 10 RD_ADDR: `rd_ptr` ← payload[ADDR_W-1:0]; set `rd_armed`.
  - 11 RD_DATA: `dout` ← `mem[rd_ptr]`; pulse `tx_valid`.
- Rejections: each rejected command pulses `err`, leaves all state unchanged, and produces no `tx_valid`.
  - WR_DATA while `wr_armed`=0.
  - RD_DATA while `rd_armed`=0.
  - WR_ADDR or RD_ADDR with payload ≥ MEM_DEPTH. This includes nonzero payload bits above ADDR_W.
- Auto-increment, only when AUTO_INC=1:
  - After an accepted WR_DATA, `wr_ptr` ← `wr_ptr`+1. After an accepted RD_DATA, `rd_ptr` ← `rd_ptr`+1.
  - Both pointers wrap from MEM_DEPTH-1 to 0.
- When AUTO_INC=0, pointers change only on address commands.
- Pointers are independent. A WR_DATA never moves `rd_ptr`, and the reverse also holds.
- `dout` holds its last read value until the next accepted RD_DATA.
- Reset:
  - Asserting `rst_n` low at any time, including mid-burst, immediately clears: `dout`=0, `tx_valid`=0, `err`=0, `wr_ptr`=`rd_ptr`=0, `wr_armed`=`rd_armed`=0.
  - Memory contents are not reset and are retained across reset.
- Opcode X/Z with `rx_valid`=1 is treated as no command.

## Timing
- Every command is sampled at the posedge where `rx_valid`=1.
- Write latency 0: a write committed at edge N is readable by an RD_DATA sampled at edge N+1.
- Read latency 1: for RD_DATA sampled at edge N, `dout` and `tx_valid` are updated by edge N; visible during cycle N→N+1.
- `tx_valid` is high for exactly one cycle per accepted RD_DATA. Back-to-back RD_DATA keeps it high on consecutive cycles, with a new `dout` each cycle.
- `err` is registered the same way: it is high during the cycle after the offending edge.
- Pointer updates, including auto-increment, take effect at the same edge. A command at edge N+1 uses the updated pointer.
- No backpressure: the downstream serialiser must accept each `tx_valid` pulse.

## Structure
- Package `spi_ram_pkg`: opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11, and the `opcode_t` typedef.
- Sub-module `spi_ram_mem`: un-reset DATA_W × MEM_DEPTH array with a synchronous write port and a synchronous registered read port.
- The top level holds the decoder, pointers, armed flags, and the `err`/`tx_valid` registers.

## Test plan
All scenarios use defaults unless stated.
- Single access: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA → `dout`=0xA5 with a 1-cycle `tx_valid` one cycle after the RD_DATA edge; `err` never asserts.
- Disarmed commands: after reset, RD_DATA → `err` pulse, no `tx_valid`, `dout`=0. Likewise WR_DATA → `err` pulse and the memory is unchanged.
- Burst with wrap: AUTO_INC=1, MEM_DEPTH=5, DATA_W=8. WR_ADDR 4, then WR_DATA 0x11, 0x22, 0x33; RD_ADDR 4, then 3× RD_DATA.
  - Required: `dout` sequence 0x11, 0x22, 0x33 (addresses 4, 0, 1) on three consecutive `tx_valid` cycles.
- Range check: MEM_DEPTH=200, WR_ADDR 0xC8 → `err` pulse and `wr_armed` stays 0. A following WR_DATA also pulses `err`.
- Reset mid-burst: AUTO_INC=1, reset asserted asynchronously between clock edges during a read burst.
  - Required: `tx_valid`, `dout` and `err` go to 0 immediately.
  - After release, RD_DATA → `err`; RD_ADDR 0, RD_DATA → the pre-reset memory value.
- `rx_valid` gating: opcode 11 with `rx_valid`=0 for 10 cycles → no `tx_valid`, no `err`, and `rd_ptr` unchanged.
